// File: rtl/dff_pipe_chain_pkg.sv
// Shared definitions for the dff_pipe_chain retiming pipe: occupancy update
// operations and the rule that picks one from the transfer events of a cycle.
package dff_pipe_chain_pkg;

    typedef enum logic [1:0] {
        OCC_HOLD,
        OCC_INC,
        OCC_DEC,
        OCC_CLEAR
    } occ_op_e;

    // Flush wins over everything; a simultaneous accept and consume cancel out.
    function automatic occ_op_e occ_op(input logic flush, input logic accept, input logic consume);
        if (flush)
            return OCC_CLEAR;
        if (accept && !consume)
            return OCC_INC;
        if (!accept && consume)
            return OCC_DEC;
        return OCC_HOLD;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One stage of the pipe: a valid bit plus a data word, loaded under an enable.
// Flush clears the valid bit only; data is written only by a valid incoming word.
module pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // NOTE: sequential state is assigned with <= so every stage samples its
    // upstream neighbour's pre-edge value, whatever order the simulator runs them in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            // NOTE: the data word is reset too, because out_data must show
            // RESET_VAL immediately on reset, not whatever was last in flight.
            data_q  <= RESET_VAL;
        end else begin
            if (flush_i)
                valid_q <= 1'b0;
            else if (load_i)
                valid_q <= valid_i;

            if (load_i && valid_i && !flush_i)
                data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/dff_pipe_chain.sv
// STAGES-deep valid/ready register pipe with backpressure, bubble collapse,
// synchronous flush and a registered occupancy count.
module dff_pipe_chain
    import dff_pipe_chain_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               STAGES    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;
    logic [WIDTH-1:0]  d [STAGES];
    logic              chain_rdy;
    logic              accept;
    logic              consume;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;

    // A stage may load when it is empty or everything downstream of it can move.
    always_comb begin
        // NOTE: chain_rdy is a combinational temporary; blocking = lets each
        // loop iteration see the value produced by the previous one.
        chain_rdy = out_ready;
        rdy       = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain_rdy = chain_rdy | !v[i];
            rdy[i]    = chain_rdy;
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_link
            assign up_valid = v[i-1];
            assign up_data  = d[i-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .flush_i (flush),
            .load_i  (rdy[i]),
            .valid_i (up_valid),
            .data_i  (up_data),
            .valid_o (v[i]),
            .data_o  (d[i])
        );
    end

    assign in_ready  = rdy[0] & !flush & reset_n;
    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    always_comb begin
        // NOTE: occ_d gets its hold value first so no path leaves it unassigned
        // and no latch is inferred.
        occ_d = occ_q;
        unique case (occ_op(flush, accept, consume))
            OCC_INC:   occ_d = occ_q + OCC_W'(1);
            OCC_DEC:   occ_d = occ_q - OCC_W'(1);
            OCC_CLEAR: occ_d = '0;
            OCC_HOLD:  occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            occ_q <= '0;
        else
            occ_q <= occ_d;
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_dff_pipe_chain.sv
// Self-checking bench for dff_pipe_chain (WIDTH=8, STAGES=4): a streaming
// vector table, directed corner sequences and random traffic against a queue model.
module tb_dff_pipe_chain;

    localparam int WIDTH  = 8;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [2:0]       occupancy;

    dff_pipe_chain #(
        .WIDTH     (WIDTH),
        .STAGES    (STAGES),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: words in flight, oldest first, with their acceptance edge.
    // The oldest word never waits behind anything, so it reaches the output
    // STAGES-1 edges after the edge that accepted it.
    logic [WIDTH-1:0] model_q [$];
    int               stamp_q [$];
    int               cyc = 0;
    logic             exp_ir, exp_ov, acc, con, cur_fl;
    logic [WIDTH-1:0] cur_id;

    task automatic drive(input logic iv, input logic [WIDTH-1:0] id, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_ir = !fl && ((model_q.size() < STAGES) || ordy);
        exp_ov = (model_q.size() > 0) && ((cyc - stamp_q[0]) >= STAGES - 1);
        acc    = iv && exp_ir;
        con    = exp_ov && ordy && !fl;
        cur_fl = fl;
        cur_id = id;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (cur_fl) begin
            model_q.delete();
            stamp_q.delete();
        end else begin
            if (con) begin
                void'(model_q.pop_front());
                void'(stamp_q.pop_front());
            end
            if (acc) begin
                model_q.push_back(cur_id);
                stamp_q.push_back(cyc);
            end
        end
    endtask

    task automatic model_check(input string tag);
        check({tag, "_in_ready"},  in_ready,  exp_ir);
        check({tag, "_out_valid"}, out_valid, exp_ov);
        check({tag, "_occupancy"}, occupancy, model_q.size());
        if (exp_ov)
            check({tag, "_out_data"}, out_data, model_q[0]);
    endtask

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] id;
        logic             ordy;
        logic             ir;
        logic             ov;
        logic [WIDTH-1:0] od;
        logic [2:0]       occ;
    } vec_t;

    vec_t             vecs [20];
    logic [WIDTH-1:0] captured [$];
    logic [WIDTH-1:0] word;

    initial begin
        // Streaming 8'h01..8'h10 then four idle cycles, out_ready held high.
        for (int k = 0; k < 20; k++) begin
            vecs[k].iv   = (k < 16);
            vecs[k].id   = (k < 16) ? 8'(k + 1) : 8'h00;
            vecs[k].ordy = 1'b1;
            vecs[k].ir   = 1'b1;
            vecs[k].ov   = (k >= 4);
            vecs[k].od   = (k < 4) ? 8'h00 : 8'(k - 3);
            vecs[k].occ  = (k <= 16) ? 3'((k < 4) ? k : 4) : 3'(20 - k);
        end

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cur_fl    = 1'b0;
        acc       = 1'b0;
        con       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_out_data",  out_data,  8'h00);
        check("rst_in_ready",  in_ready,  0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < 20; k++) begin
            drive(vecs[k].iv, vecs[k].id, vecs[k].ordy, 1'b0);
            check($sformatf("stream%0d_in_ready", k),  in_ready,  vecs[k].ir);
            check($sformatf("stream%0d_out_valid", k), out_valid, vecs[k].ov);
            check($sformatf("stream%0d_out_data", k),  out_data,  vecs[k].od);
            check($sformatf("stream%0d_occupancy", k), occupancy, vecs[k].occ);
            tick();
        end

        // Backpressure: two pushes, consumer stalls, keep pushing until full.
        drive(1'b1, 8'hA0, 1'b1, 1'b0); model_check("bp"); tick();
        drive(1'b1, 8'hA1, 1'b1, 1'b0); model_check("bp"); tick();
        word = 8'hA2;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, word, 1'b0, 1'b0);
            model_check("bp_fill");
            if (exp_ir)
                word = word + 8'h01;
            tick();
        end
        drive(1'b1, word, 1'b0, 1'b0);
        check("bp_full_in_ready", in_ready, 0);
        check("bp_full_occupancy", occupancy, 4);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            model_check("bp_drain");
            if (out_valid)
                captured.push_back(out_data);
            tick();
        end
        check("bp_count", captured.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < captured.size())
                check($sformatf("bp_word%0d", i), captured[i], 8'hA0 + 8'(i));

        // Bubble collapse under a stalled consumer.
        drive(1'b1, 8'h11, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0, 1'b0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0); model_check("bub"); tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("bub_occupancy", occupancy, 2);
        check("bub_head_data", out_data, 8'h11);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("bub_first_valid", out_valid, 1);
        check("bub_first_data",  out_data,  8'h11);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("bub_adjacent_valid", out_valid, 1);
        check("bub_adjacent_data",  out_data,  8'h22);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("bub_empty_occupancy", occupancy, 0);
        tick();

        // Flush with three words in flight and a word offered at the same edge.
        drive(1'b1, 8'hB1, 1'b1, 1'b0); tick();
        drive(1'b1, 8'hB2, 1'b1, 1'b0); tick();
        drive(1'b1, 8'hB3, 1'b1, 1'b0); tick();
        drive(1'b1, 8'h55, 1'b1, 1'b1);
        check("flush_in_ready", in_ready, 0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("flush_out_valid", out_valid, 0);
        check("flush_occupancy", occupancy, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            model_check("flush_after");
            check("flush_no_55", out_valid && (out_data == 8'h55), 0);
            tick();
        end

        // Full chain with simultaneous accept and consume for ten cycles.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0); tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'hE0 + 8'(i), 1'b1, 1'b0);
            check("full_xfer_occupancy", occupancy, 4);
            model_check("full_xfer");
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0); model_check("full_drain"); tick();
        end

        // Reset mid-stream with three words in flight, head word on the output.
        drive(1'b1, 8'hC1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hC2, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hC3, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        model_check("pre_rst");
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_occupancy", occupancy, 0);
        check("mid_rst_out_data",  out_data,  8'h00);
        check("mid_rst_in_ready",  in_ready,  0);
        model_q.delete();
        stamp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_in_ready", in_ready, 1);
        model_check("post_rst");
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 3);
            model_check("rand");
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0); model_check("rand_drain"); tick();
        end
        check("rand_final_occupancy", occupancy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
